uart_puente_fifo: RTL
=====================

Name: uart_puente_fifo

Overview:
- Parametrised successor to the UART echo bridge: sits between the uart core's receive side (data_out, rx_done_tick) and its transmit side (data_in, tx_start, tx_done_tick).
- Received words are buffered in a FIFO and retransmitted one at a time, so words arriving while the transmitter is busy are not lost.
- A parameter selects a payload transform for link testing.
- Status outputs (count, overflow, state) drive board LEDs.

Parameters:
NBITS, 8, data word width; must match the uart core's NBITS.
LOG2_DEPTH, 4, FIFO depth = 2**LOG2_DEPTH words (4 -> 16 words).
MODE, 0, payload transform: 0 = pass-through; 1 = increment modulo 2**NBITS; 2 = bitwise invert.

Ports:
CLK_100MHZ  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  NBITS  received word from the uart core; valid when rx_done_tick=1.
rx_done_tick  input  1  one-cycle pulse, a word was received.
tx_done_tick  input  1  one-cycle pulse, the transmitter finished a word.
tx_data  output  NBITS  word for the uart core's data_in; registered and held stable from the tx_start cycle until tx_done_tick.
tx_start  output  1  one-cycle transmit request.
fifo_count  output  LOG2_DEPTH+1  number of words currently stored.
overflow  output  1  sticky flag, a received word was dropped.
state  output  2  FSM state encoding, for LEDs.

Behaviour:
Interface decision (fixed):
- One clock, CLK_100MHZ.
- Reset port is reset: synchronous and active-high.

Reset:
- Applies at any time, including mid-transmission.
- Outputs: tx_start=0, tx_data=0, fifo_count=0, overflow=0, state=IDLE (2'b00).
- FIFO read and write pointers are cleared; stored contents are discarded.

FIFO:
- Circular buffer with read and write pointers of width LOG2_DEPTH; pointers wrap from DEPTH-1 to 0.
- Full when fifo_count==DEPTH; empty when fifo_count==0.

Push:
- Occurs on rx_done_tick=1 when not full, or when full and a pop happens in the same cycle.
- On push: write rx_data at the write pointer, then advance the write pointer.

Drop:
- Occurs on rx_done_tick=1 when full with no pop in the same cycle.
- The word is discarded and overflow is set to 1.
- overflow clears only on reset.

Count update:
- Push and pop in the same cycle: fifo_count is unchanged.
- Push only: +1. Pop only: -1.

FSM:
- IDLE (00):
  - If not empty: pop the head; tx_data <= f(head); go to START.
  - Otherwise stay in IDLE.
- START (01):
  - tx_start=1 for exactly this cycle; go to WAIT.
- WAIT (10):
  - Stay until tx_done_tick=1, then go to IDLE.
- tx_done_tick is ignored in IDLE and START.
- Encoding 11 is unused and recovers to IDLE.
- Pops occur only in IDLE.

Transform f:
- MODE 0: f(x) = x.
- MODE 1: f(x) = x+1, truncated to NBITS (so 0xFF -> 0x00 for NBITS=8).
- MODE 2: f(x) = ~x.

Latency:
- rx_done_tick at cycle t, with the FIFO empty and the FSM in IDLE: tx_start=1 at cycle t+2, with tx_data=f(word).
- tx_done_tick at cycle u, with the FIFO not empty: next tx_start=1 at cycle u+2.

Input rules:
- rx_done_tick is accepted in every state, independent of the FSM.
- Reception continues while a word is being transmitted.

Test Plan:
1. MODE=0: reset, then one rx_done_tick with rx_data=0x41 at cycle t -> tx_start=1 only at cycle t+2, tx_data=0x41; after tx_done_tick, state returns to 00 and fifo_count=0.
2. MODE=0, no tx_done_tick returned: push 0x01, 0x02, 0x03 back-to-back -> fifo_count peaks at 2 (0x01 already popped); then pulse tx_done_tick three times -> transmitted order is 0x01, 0x02, 0x03, each tx_start exactly 2 cycles after the preceding tx_done_tick.
3. LOG2_DEPTH=2, tx stalled: push 6 words 0x10..0x15 -> 0x10 is in flight, 0x11..0x14 are stored (fifo_count=4), 0x15 is dropped and overflow=1; drain -> output is 0x10..0x14 and overflow stays 1.
4. Full FIFO (count=4), rx_done_tick with 0xAA in the same cycle as an IDLE pop -> push accepted, count stays 4, overflow stays 0, 0xAA transmitted last.
5. MODE=1: input 0xFF -> tx_data=0x00. MODE=2: input 0x5A -> tx_data=0xA5.
6. Reset asserted during WAIT with fifo_count=3 -> next cycle state=00, fifo_count=0, tx_start=0, tx_data=0, overflow=0; a later tx_done_tick causes no tx_start.

Source files
------------

// File: rtl/uart_puente_fifo_if.sv
// UART bridge bus: receive side, transmit side and LED status.
// slave is the bridge, master is the uart core / board side.
interface uart_puente_fifo_if #(
   parameter int NBITS      = 8,
   parameter int LOG2_DEPTH = 4
);
   logic [NBITS-1:0]    rx_data;
   logic                rx_done_tick;
   logic                tx_done_tick;
   logic [NBITS-1:0]    tx_data;
   logic                tx_start;
   logic [LOG2_DEPTH:0] fifo_count;
   logic                overflow;
   logic [1:0]          state;

   modport master (
      output rx_data, rx_done_tick, tx_done_tick,
      input  tx_data, tx_start, fifo_count, overflow, state
   );

   modport slave (
      input  rx_data, rx_done_tick, tx_done_tick,
      output tx_data, tx_start, fifo_count, overflow, state
   );
endinterface

// File: rtl/uart_puente_fifo.sv
// UART echo bridge with receive FIFO and optional payload transform.
// Words are retransmitted in arrival order, one per tx handshake.
module uart_puente_fifo #(
   parameter int NBITS      = 8,
   parameter int LOG2_DEPTH = 4,
   parameter int MODE       = 0
) (
   input  logic              CLK_100MHZ,
   input  logic              reset,
   uart_puente_fifo_if.slave bus
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      WAIT  = 2'b10
   } state_t;

   logic [NBITS-1:0]      mem_q [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG2_DEPTH:0]   count_q, count_d;
   logic                  ovf_q;
   state_t                state_q;
   logic                  tx_start_q;
   logic [NBITS-1:0]      tx_data_q;

   logic full, empty, pop, push, drop;

   function automatic logic [NBITS-1:0] xform(input logic [NBITS-1:0] x);
      case (MODE)
         1:       return x + NBITS'(1);
         2:       return ~x;
         default: return x;
      endcase
   endfunction

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   // a pop frees a slot in the same cycle, so a full FIFO can still accept
   assign pop   = (state_q == IDLE) && !empty;
   assign push  = bus.rx_done_tick && (!full || pop);
   assign drop  = bus.rx_done_tick && full && !pop;

   // next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   // storage array, contents need no reset
   always_ff @(posedge CLK_100MHZ) begin
      if (!reset && push) mem_q[wr_ptr_q] <= bus.rx_data;
   end

   // pointers, occupancy and sticky overflow
   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (drop) ovf_q <= 1'b1;
      end
   end

   // transmit sequencer: pop in IDLE, pulse in START, hold until done
   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  tx_data_q  <= xform(mem_q[rd_ptr_q]);
                  tx_start_q <= 1'b1;
                  state_q    <= START;
               end
            end
            START: state_q <= WAIT;
            WAIT:  if (bus.tx_done_tick) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_start   = tx_start_q;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.state      = state_q;
endmodule
